video_timing_detector: RTL and testbench

VIDEO_TIMING_DETECTOR -- requirements
Module: video_timing_detector

---
 rtl/video_timing_detector.sv | 191 +++++++++++++++++++
 tb/tb_video_timing_detector.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - measures sync timing and locks once consecutive frames agree
// Build option VTD_POLARITY_DETECT_EN: learn each sync polarity instead of assuming active-low.
module video_timing_detector #(
  parameter int C_COUNTER_WIDTH = 12,
  parameter int C_LOCK_FRAMES   = 2,
  parameter int C_USE_BLANKING  = 1
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_nHSync,
  input  logic                       i_nVSync,
  input  logic                       i_HBlank,
  input  logic                       i_VBlank,
  output logic                       o_Locked,
  output logic [C_COUNTER_WIDTH-1:0] o_Width,
  output logic [C_COUNTER_WIDTH-1:0] o_Height,
  output logic [C_COUNTER_WIDTH-1:0] o_LineTotal,
  output logic [C_COUNTER_WIDTH-1:0] o_FrameTotal,
  output logic                       o_NewFrame
);
  localparam int W = C_COUNTER_WIDTH;
  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] LOCK_N   = W'(C_LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  logic [1:0] sync_raw, act, act_q;
  logic       pol_change;
  assign sync_raw = {i_nVSync, i_nHSync};

`ifdef VTD_POLARITY_DETECT_EN
  logic [1:0]   pol, pol_nxt, raw_q, seen;
  logic [W-1:0] hi_cnt [2];
  logic [W-1:0] lo_cnt [2];

  always_comb begin
    pol_nxt = pol;
    for (int i = 0; i < 2; i++)
      if (sync_raw[i] && !raw_q[i] && seen[i]) pol_nxt[i] = (hi_cnt[i] < lo_cnt[i]);
  end

  // A period closes at each rising level; the first one after reset is partial and only arms seen.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pol   <= '0;
      raw_q <= '1;
      seen  <= '0;
      for (int i = 0; i < 2; i++) begin
        hi_cnt[i] <= '0;
        lo_cnt[i] <= '0;
      end
    end else begin
      pol   <= pol_nxt;
      raw_q <= sync_raw;
      for (int i = 0; i < 2; i++) begin
        if (sync_raw[i] && !raw_q[i]) begin
          seen[i]   <= 1'b1;
          hi_cnt[i] <= W'(1);
          lo_cnt[i] <= '0;
        end else if (sync_raw[i]) begin
          if (hi_cnt[i] != ALL_ONES) hi_cnt[i] <= hi_cnt[i] + 1'b1;
        end else if (lo_cnt[i] != ALL_ONES) begin
          lo_cnt[i] <= lo_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pol_change = (pol_nxt != pol);
  assign act        = ~(sync_raw ^ pol);
`else
  assign pol_change = 1'b0;
  assign act        = ~sync_raw;
`endif

  state_t       state;
  logic         hs_edge, vs_edge, timeout, s_valid, match_stored, match_pub;
  logic [W-1:0] line_cnt, line_nxt, act_cnt, match_cnt;
  logic [W-1:0] f_lines, f_act_lines, f_max_act, f_line_total;
  logic [W-1:0] c_lines, c_act_lines, c_max_act, c_line_total;
  logic [W-1:0] m_width, m_height, s_width, s_height, s_ltotal, s_ftotal;

  assign vs_edge = o_NewFrame;

  // Closing-frame view: a same-cycle hsync edge still belongs to the frame being closed.
  always_comb begin
    line_nxt     = (line_cnt == ALL_ONES) ? line_cnt : line_cnt + 1'b1;
    timeout      = !hs_edge && (line_nxt == ALL_ONES);
    c_lines      = f_lines;
    c_act_lines  = f_act_lines;
    c_max_act    = f_max_act;
    c_line_total = f_line_total;
    if (hs_edge) begin
      c_lines      = f_lines + 1'b1;
      c_line_total = line_cnt;
      if (act_cnt != '0) c_act_lines = f_act_lines + 1'b1;
      if (act_cnt > f_max_act) c_max_act = act_cnt;
    end
    m_width      = (C_USE_BLANKING != 0) ? c_max_act : c_line_total;
    m_height     = (C_USE_BLANKING != 0) ? c_act_lines : c_lines;
    match_stored = s_valid && (m_width == s_width) && (m_height == s_height) &&
                   (c_line_total == s_ltotal) && (c_lines == s_ftotal);
    match_pub    = (m_width == o_Width) && (m_height == o_Height) &&
                   (c_line_total == o_LineTotal) && (c_lines == o_FrameTotal);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      act_q        <= '0;
      hs_edge      <= 1'b0;
      o_NewFrame   <= 1'b0;
      line_cnt     <= '0;
      act_cnt      <= '0;
      f_lines      <= '0;
      f_act_lines  <= '0;
      f_max_act    <= '0;
      f_line_total <= '0;
    end else begin
      act_q      <= act;
      hs_edge    <= act[0] & ~act_q[0];
      o_NewFrame <= act[1] & ~act_q[1];
      line_cnt   <= hs_edge ? W'(1) : line_nxt;
      if (hs_edge) act_cnt <= W'(!i_HBlank && !i_VBlank);
      else if (!i_HBlank && !i_VBlank && act_cnt != ALL_ONES) act_cnt <= act_cnt + 1'b1;
      f_lines      <= vs_edge ? '0 : c_lines;
      f_act_lines  <= vs_edge ? '0 : c_act_lines;
      f_max_act    <= vs_edge ? '0 : c_max_act;
      f_line_total <= vs_edge ? '0 : c_line_total;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= UNLOCKED;
      o_Locked     <= 1'b0;
      match_cnt    <= '0;
      s_valid      <= 1'b0;
      s_width      <= '0;
      s_height     <= '0;
      s_ltotal     <= '0;
      s_ftotal     <= '0;
      o_Width      <= '0;
      o_Height     <= '0;
      o_LineTotal  <= '0;
      o_FrameTotal <= '0;
    end else if (timeout || pol_change) begin
      state    <= UNLOCKED;
      o_Locked <= 1'b0;
    end else if (vs_edge) begin
      case (state)
        UNLOCKED: begin
          state     <= ACQUIRE;
          match_cnt <= '0;
          s_valid   <= 1'b0;
        end
        ACQUIRE: begin
          s_valid  <= 1'b1;
          s_width  <= m_width;
          s_height <= m_height;
          s_ltotal <= c_line_total;
          s_ftotal <= c_lines;
          if (!match_stored) begin
            match_cnt <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt + 1'b1 >= LOCK_N) begin
              state        <= LOCKED;
              o_Locked     <= 1'b1;
              o_Width      <= m_width;
              o_Height     <= m_height;
              o_LineTotal  <= c_line_total;
              o_FrameTotal <= c_lines;
            end
          end
        end
        default: begin
          if (!match_pub) begin
            state     <= ACQUIRE;
            o_Locked  <= 1'b0;
            match_cnt <= '0;
            s_valid   <= 1'b1;
            s_width   <= m_width;
            s_height  <= m_height;
            s_ltotal  <= c_line_total;
            s_ftotal  <= c_lines;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_video_timing_detector.sv
// tb/tb_video_timing_detector.sv - directed scenarios for video_timing_detector
module tb_video_timing_detector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_Rst, i_nHSync, i_nVSync, i_HBlank, i_VBlank;
  logic       o_Locked, o_NewFrame, nb_locked, nb_newframe;
  logic [7:0] o_Width, o_Height, o_LineTotal, o_FrameTotal;
  logic [7:0] nb_width, nb_height, nb_ltotal, nb_ftotal;

  video_timing_detector #(.C_COUNTER_WIDTH(8), .C_LOCK_FRAMES(2), .C_USE_BLANKING(1)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_nHSync(i_nHSync), .i_nVSync(i_nVSync),
    .i_HBlank(i_HBlank), .i_VBlank(i_VBlank), .o_Locked(o_Locked),
    .o_Width(o_Width), .o_Height(o_Height), .o_LineTotal(o_LineTotal),
    .o_FrameTotal(o_FrameTotal), .o_NewFrame(o_NewFrame));

  video_timing_detector #(.C_COUNTER_WIDTH(8), .C_LOCK_FRAMES(2), .C_USE_BLANKING(0)) dut_nb (
    .i_Clk(clk), .i_Rst(i_Rst), .i_nHSync(i_nHSync), .i_nVSync(i_nVSync),
    .i_HBlank(i_HBlank), .i_VBlank(i_VBlank), .o_Locked(nb_locked),
    .o_Width(nb_width), .o_Height(nb_height), .o_LineTotal(nb_ltotal),
    .o_FrameTotal(nb_ftotal), .o_NewFrame(nb_newframe));

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, nf_cnt = 0, last_nf_cyc = 0, last_hs_cyc = 0;
  int   rise_cyc = -1, rise_nf = -1, rise_gap = -1;
  int   fall_cyc = -1, fall_nf = -1, fall_gap = -1;
  logic lk_prev = 1'b0, hs_prev = 1'b1, inv = 1'b0;

  // hs/vs are the logical active-low levels; inv flips them onto the pins.
  task automatic tick(input logic hs, input logic vs, input logic hb, input logic vb, input logic rst);
    i_Rst = rst; i_nHSync = hs ^ inv; i_nVSync = vs ^ inv; i_HBlank = hb; i_VBlank = vb;
    @(posedge clk); #1;
    cyc++;
    if (!hs && hs_prev) last_hs_cyc = cyc;
    hs_prev = hs;
    if (o_NewFrame === 1'b1) begin nf_cnt++; last_nf_cyc = cyc; end
    if (o_Locked === 1'b1 && lk_prev !== 1'b1) begin rise_cyc = cyc; rise_nf = nf_cnt; rise_gap = cyc - last_nf_cyc; end
    if (o_Locked === 1'b0 && lk_prev === 1'b1) begin fall_cyc = cyc; fall_nf = nf_cnt; fall_gap = cyc - last_nf_cyc; end
    lk_prev = o_Locked;
  endtask

  // Line: 8-clock hsync, active clocks 8..39; frame: 2-line vsync, active lines 6..29.
  task automatic px(input int l, input int c, input logic rst);
    tick(c >= 8, l >= 2, (c < 8) || (c >= 40), l < 6, rst);
  endtask

  task automatic drive_lines(input int first, input int last, input logic long_last);
    for (int l = first; l <= last; l++)
      for (int c = 0; c < ((long_last && l == 29) ? 41 : 40); c++) px(l, c, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    nf_cnt = 0;
    n_checks++; if (o_Locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", o_Locked); end
    n_checks++; if (o_NewFrame !== 1'b0) begin n_fail++; $display("FAIL reset_newframe: got %b expected 0", o_NewFrame); end
    n_checks++; if (o_Width !== 8'd0) begin n_fail++; $display("FAIL reset_width: got %0d expected 0", o_Width); end
    n_checks++; if (o_Height !== 8'd0) begin n_fail++; $display("FAIL reset_height: got %0d expected 0", o_Height); end
    n_checks++; if (o_LineTotal !== 8'd0) begin n_fail++; $display("FAIL reset_linetotal: got %0d expected 0", o_LineTotal); end
    n_checks++; if (o_FrameTotal !== 8'd0) begin n_fail++; $display("FAIL reset_frametotal: got %0d expected 0", o_FrameTotal); end
  endtask

  task automatic test_lock();
    rise_nf = -1; rise_gap = -1;
    for (int f = 0; f < 4; f++) drive_lines(0, 29, 1'b0);
    n_checks++; if (rise_nf !== 4) begin n_fail++; $display("FAIL lock_vsync_count: got %0d expected 4", rise_nf); end
    n_checks++; if (rise_gap !== 1) begin n_fail++; $display("FAIL lock_latency: got %0d expected 1", rise_gap); end
    n_checks++; if (nf_cnt !== 4) begin n_fail++; $display("FAIL lock_newframe_pulses: got %0d expected 4", nf_cnt); end
    n_checks++; if (o_Locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %b expected 1", o_Locked); end
    n_checks++; if (o_Width !== 8'd32) begin n_fail++; $display("FAIL lock_width: got %0d expected 32", o_Width); end
    n_checks++; if (o_Height !== 8'd24) begin n_fail++; $display("FAIL lock_height: got %0d expected 24", o_Height); end
    n_checks++; if (o_LineTotal !== 8'd40) begin n_fail++; $display("FAIL lock_linetotal: got %0d expected 40", o_LineTotal); end
    n_checks++; if (o_FrameTotal !== 8'd30) begin n_fail++; $display("FAIL lock_frametotal: got %0d expected 30", o_FrameTotal); end
  endtask

  task automatic test_no_blanking();
    fall_cyc = -1;
    drive_lines(0, 29, 1'b0);
    n_checks++; if (fall_cyc !== -1) begin n_fail++; $display("FAIL stable_no_drop: dropped at cycle %0d expected none", fall_cyc); end
    n_checks++; if (nb_locked !== 1'b1) begin n_fail++; $display("FAIL noblank_locked: got %b expected 1", nb_locked); end
    n_checks++; if (nb_width !== 8'd40) begin n_fail++; $display("FAIL noblank_width: got %0d expected 40", nb_width); end
    n_checks++; if (nb_height !== 8'd30) begin n_fail++; $display("FAIL noblank_height: got %0d expected 30", nb_height); end
    n_checks++; if (nb_ftotal !== 8'd30) begin n_fail++; $display("FAIL noblank_frametotal: got %0d expected 30", nb_ftotal); end
  endtask

  task automatic test_mismatch();
    int nf_before;
    drive_lines(0, 29, 1'b1);
    n_checks++; if (o_Locked !== 1'b1) begin n_fail++; $display("FAIL mismatch_early_drop: got %b expected 1", o_Locked); end
    nf_before = nf_cnt; fall_nf = -1; fall_gap = -1;
    drive_lines(0, 29, 1'b0);
    n_checks++; if (fall_nf !== nf_before + 1) begin n_fail++; $display("FAIL mismatch_drop_frame: got %0d expected %0d", fall_nf, nf_before + 1); end
    n_checks++; if (fall_gap !== 1) begin n_fail++; $display("FAIL mismatch_drop_latency: got %0d expected 1", fall_gap); end
    n_checks++; if (o_Locked !== 1'b0) begin n_fail++; $display("FAIL mismatch_unlocked: got %b expected 0", o_Locked); end
    n_checks++; if ({o_Width, o_Height, o_LineTotal, o_FrameTotal} !== {8'd32, 8'd24, 8'd40, 8'd30}) begin
      n_fail++; $display("FAIL mismatch_hold: got %0d/%0d/%0d/%0d expected 32/24/40/30", o_Width, o_Height, o_LineTotal, o_FrameTotal);
    end
    rise_nf = -1; rise_gap = -1;
    for (int f = 0; f < 3; f++) drive_lines(0, 29, 1'b0);
    n_checks++; if (rise_nf - fall_nf !== 3) begin n_fail++; $display("FAIL relock_vsync_count: got %0d expected 3", rise_nf - fall_nf); end
    n_checks++; if (rise_gap !== 1) begin n_fail++; $display("FAIL relock_latency: got %0d expected 1", rise_gap); end
    n_checks++; if (o_Locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked: got %b expected 1", o_Locked); end
  endtask

  task automatic test_timeout();
    drive_lines(0, 9, 1'b0);
    n_checks++; if (o_Locked !== 1'b1) begin n_fail++; $display("FAIL timeout_pre_locked: got %b expected 1", o_Locked); end
    fall_cyc = -1;
    for (int k = 0; k < 300; k++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if (fall_cyc - last_hs_cyc !== 255) begin n_fail++; $display("FAIL timeout_delay: got %0d expected 255", fall_cyc - last_hs_cyc); end
    n_checks++; if (o_Locked !== 1'b0) begin n_fail++; $display("FAIL timeout_unlocked: got %b expected 0", o_Locked); end
    n_checks++; if (o_Width !== 8'd32) begin n_fail++; $display("FAIL timeout_hold_width: got %0d expected 32", o_Width); end
  endtask

  task automatic test_reset_mid_frame();
    int nf_base;
    for (int f = 0; f < 4; f++) drive_lines(0, 29, 1'b0);
    n_checks++; if (o_Locked !== 1'b1) begin n_fail++; $display("FAIL midrst_prelock: got %b expected 1", o_Locked); end
    drive_lines(0, 14, 1'b0);
    for (int c = 0; c < 20; c++) px(15, c, 1'b0);
    px(15, 20, 1'b1);
    n_checks++; if ({o_Locked, o_NewFrame} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b%b expected 00", o_Locked, o_NewFrame); end
    n_checks++; if ({o_Width, o_Height, o_LineTotal, o_FrameTotal} !== 32'd0) begin
      n_fail++; $display("FAIL midrst_values: got %0d/%0d/%0d/%0d expected 0/0/0/0", o_Width, o_Height, o_LineTotal, o_FrameTotal);
    end
    n_checks++; if (nb_locked !== 1'b0) begin n_fail++; $display("FAIL midrst_nb_locked: got %b expected 0", nb_locked); end
    nf_base = nf_cnt; rise_nf = -1;
    for (int c = 21; c < 40; c++) px(15, c, 1'b0);
    drive_lines(16, 29, 1'b0);
    for (int f = 0; f < 4; f++) drive_lines(0, 29, 1'b0);
    n_checks++; if (rise_nf - nf_base !== 4) begin n_fail++; $display("FAIL midrst_relock_count: got %0d expected 4", rise_nf - nf_base); end
    n_checks++; if ({o_Width, o_Height, o_LineTotal, o_FrameTotal} !== {8'd32, 8'd24, 8'd40, 8'd30}) begin
      n_fail++; $display("FAIL midrst_relock_values: got %0d/%0d/%0d/%0d expected 32/24/40/30", o_Width, o_Height, o_LineTotal, o_FrameTotal);
    end
  endtask

`ifdef VTD_POLARITY_DETECT_EN
  task automatic test_polarity();
    inv = 1'b1;
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int f = 0; f < 8; f++) drive_lines(0, 29, 1'b0);
    n_checks++; if (o_Locked !== 1'b1) begin n_fail++; $display("FAIL polarity_locked: got %b expected 1", o_Locked); end
    n_checks++; if ({o_Width, o_Height, o_LineTotal, o_FrameTotal} !== {8'd32, 8'd24, 8'd40, 8'd30}) begin
      n_fail++; $display("FAIL polarity_values: got %0d/%0d/%0d/%0d expected 32/24/40/30", o_Width, o_Height, o_LineTotal, o_FrameTotal);
    end
    inv = 1'b0;
  endtask
`endif

  initial begin
    i_Rst = 1'b1; i_nHSync = 1'b1; i_nVSync = 1'b1; i_HBlank = 1'b1; i_VBlank = 1'b1;
    test_reset();
    test_lock();
    test_no_blanking();
    test_mismatch();
    test_timeout();
    test_reset_mid_frame();
`ifdef VTD_POLARITY_DETECT_EN
    test_polarity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
